// File: rtl/mem_pkg.sv
// Shared definitions for the load/store stage: access size codes, FSM states
// and the natural-alignment rule.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The reserved size code 2'b11 falls into the word rule
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_BYTE: return 1'b1;
      MEM_HALF: return ~off[0];
      default:  return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering: store data/byte-enables toward memory and
// load-data extraction with sign/zero extension coming back.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_data,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be   = 4'b1111;
    o_st_data = i_st_data;
    case (i_st_size)
      MEM_BYTE: begin
        o_st_be   = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      MEM_HALF: begin
        o_st_be   = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_ld_raw[7:0];
      2'd1:    w_byte = i_ld_raw[15:8];
      2'd2:    w_byte = i_ld_raw[23:16];
      default: w_byte = i_ld_raw[31:24];
    endcase
    w_half = i_ld_off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
    case (i_ld_size)
      MEM_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      MEM_HALF: o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default:  o_ld_data = i_ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one handshaked access to variable-latency data memory per
// instruction, with misalignment drop, timeout bus error and pipeline stall.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  memsize,
  input  logic        memunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_readdata;
  logic        r_misalign;
  logic        r_bus_err;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;

  logic        w_acc;
  logic        w_aligned;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;

  assign w_acc     = memread | memwrite;
  assign w_size    = (memsize == 2'b11) ? MEM_WORD : memsize;
  assign w_aligned = is_aligned(w_size, addr[1:0]);

  byte_lane_align u_align (
    .i_st_size     (w_size),
    .i_st_off      (addr[1:0]),
    .i_st_data     (writedata),
    .o_st_be       (w_be),
    .o_st_data     (w_st_data),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_ld_raw      (mem_rdata),
    .o_ld_data     (w_ld_data)
  );

  assign stall     = ((r_state == S_IDLE) & w_acc & w_aligned) | (r_state == S_REQ);
  assign mem_req   = (r_state == S_REQ);
  assign readdata  = r_readdata;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_readdata <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_off      <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc && w_aligned) begin
            r_state    <= S_REQ;
            r_we       <= memwrite;
            r_addr     <= {addr[31:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_st_data;
            r_size     <= w_size;
            r_unsigned <= memunsigned;
            r_off      <= addr[1:0];
            r_cnt      <= '0;
          end else if (w_acc) begin
            r_misalign <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state <= S_DONE;
            if (!r_we) r_readdata <= w_ld_data;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state   <= S_DONE;
            r_bus_err <= 1'b1;
            if (!r_we) r_readdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // DONE lets the instruction retire so the same access is not reissued
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues accesses and pushes
// reference-model predictions; an independent monitor pops and compares.
module tb_mem_access_unit;

  localparam int TMO = 4;
  localparam int K_ACC = 0;
  localparam int K_MIS = 1;
  localparam int K_TMO = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          cycles;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, memunsigned, mem_ack;
  logic [1:0]  memsize;
  logic [31:0] addr, writedata, mem_rdata;
  logic [31:0] readdata, mem_addr, mem_wdata;
  logic        stall, misalign, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  rec_t        q[$];
  logic [31:0] rd_model;
  int          n_chk = 0;
  int          n_pass = 0;
  int          stall_run = 0;
  int          req_run = 0;
  bit          pend = 0;
  rec_t        cur;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .memsize(memsize), .memunsigned(memunsigned), .addr(addr),
    .writedata(writedata), .readdata(readdata), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Driver: entered and left at posedge+1; models the memory responder too
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdat, input logic ack_en);
    rec_t e;
    int n;
    int off;
    logic [31:0] mask, v;
    memread = rd; memwrite = wr; memsize = sz; memunsigned = uns;
    addr = a; writedata = wd;
    if (!rd && !wr) begin
      @(posedge clk); #1;
      return;
    end
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    e.we = wr; e.addr = 0; e.be = 0; e.wdata = 0; e.cycles = 0;
    if (off % n != 0) begin
      e.kind = K_MIS; e.rd = rd_model;
      q.push_back(e);
      @(posedge clk); #1;
      memread = 0; memwrite = 0;
      return;
    end
    e.kind  = ack_en ? K_ACC : K_TMO;
    e.addr  = a & 32'hFFFF_FFFC;
    e.be    = 4'(((1 << n) - 1) << off);
    e.wdata = (n == 1) ? wd[7:0] * 32'h0101_0101 :
              (n == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    if (!wr) begin
      if (ack_en) begin
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
        v = (rdat >> (8 * off)) & mask;
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask;
        rd_model = v;
      end else begin
        rd_model = 0;
      end
    end
    e.rd = rd_model;
    e.cycles = ack_en ? waits + 1 : TMO;
    q.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < TMO; i++) begin
      if (ack_en && i == waits) begin
        mem_ack = 1; mem_rdata = rdat;
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = $urandom;
        break;
      end
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    // stray ack in DONE must be ignored
    mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    mem_ack = 0; memread = 0; memwrite = 0;
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      stall_run = 0; req_run = 0; pend = 0;
    end else begin
      if (pend) begin
        chk("done_readdata", readdata, cur.rd);
        chk("done_stall", 32'(stall), 0);
        chk("done_req_low", 32'(mem_req), 0);
        chk("done_bus_err", 32'(bus_err), 0);
        chk("req_cycles", req_run, cur.cycles);
        chk("stall_cycles", stall_run, cur.cycles + 1);
        pend = 0;
      end
      if (mem_req && mem_ack) begin
        if (q.size() == 0) chk("unexpected_ack_queue", 0, 1);
        else begin
          cur = q.pop_front();
          chk("kind_acc", cur.kind, K_ACC);
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          pend = 1;
        end
      end
      if (misalign) begin
        if (q.size() == 0) chk("unexpected_misalign", 0, 1);
        else begin
          cur = q.pop_front();
          chk("kind_mis", cur.kind, K_MIS);
          chk("mis_readdata", readdata, cur.rd);
          chk("mis_stall_run", stall_run, 0);
          chk("mis_req_low", 32'(mem_req), 0);
        end
      end
      if (bus_err) begin
        if (q.size() == 0) chk("unexpected_bus_err", 0, 1);
        else begin
          cur = q.pop_front();
          chk("kind_tmo", cur.kind, K_TMO);
          chk("tmo_readdata", readdata, cur.rd);
          chk("tmo_req_cycles", req_run, TMO);
          chk("tmo_stall_cycles", stall_run, TMO + 1);
          chk("tmo_req_low", 32'(mem_req), 0);
        end
      end
      stall_run = stall ? stall_run + 1 : 0;
      req_run   = mem_req ? req_run + 1 : 0;
    end
  end

  initial begin
    reset = 0; memread = 0; memwrite = 0; memsize = 0; memunsigned = 0;
    addr = 0; writedata = 0; mem_rdata = 0; mem_ack = 0; rd_model = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pulses", {30'd0, misalign, bus_err}, 0);
    reset = 1;

    access(1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1);
    access(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80112233, 1);
    access(1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80112233, 1);
    access(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 0, 32'h0, 1);
    access(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0, 1);
    access(1, 0, 2'b10, 0, 32'h104, 32'h0, 0, 32'h0, 0);
    access(1, 1, 2'b11, 0, 32'h108, 32'h12345678, 3, 32'h0, 1);

    // Abandon a load in REQ with reset
    memread = 1; memsize = 2'b10; addr = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0; memread = 0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_readdata", readdata, 0);
    rd_model = 0;
    @(posedge clk); #1;
    reset = 1;
    access(0, 1, 2'b00, 0, 32'h301, 32'h000000A5, 1, 32'h0, 1);

    for (int k = 0; k < 200; k++) begin
      logic r, w;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      access(r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, int'($urandom_range(0, TMO - 1)), $urandom,
             $urandom_range(0, 7) != 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
